axil_reg_master: RTL and testbench

AXI4-Lite initiator that turns simple register commands into single-beat AXI4-Lite write or read transactions toward the pixel-path control-register slave. Used by the test harness and the on-chip sequencer to program and read back pixel-path controls (e.g. invert enable at word 0) without each caller implementing the bus handshake. One transaction is outstanding at a time. Every command returns exactly one response, including on bus error or timeout.

---
 rtl/axil_reg_master_pkg.sv | 23 ++
 rtl/axil_reg_master_if.sv | 53 +++++
 rtl/axil_reg_master.sv | 207 ++++++++++++++++++++
 tb/tb_axil_reg_master.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_reg_master_pkg.sv
// Shared types and constants for the AXI4-Lite register master: FSM state
// encoding, response status codes and the bus-response decode helper.
package axil_reg_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    localparam logic [1:0] RSP_OKAY    = 2'b00;
    localparam logic [1:0] RSP_SLVERR  = 2'b10;
    localparam logic [1:0] RSP_TIMEOUT = 2'b11;

    // SLVERR and DECERR both collapse to SLVERR; OKAY and EXOKAY to OKAY.
    function automatic logic [1:0] resp_status(input logic [1:0] resp);
        return (resp inside {2'b10, 2'b11}) ? RSP_SLVERR : RSP_OKAY;
    endfunction

endpackage

// File: rtl/axil_reg_master_if.sv
// Command/response port plus AXI4-Lite initiator channels of the register master.
// master = the register master itself; slave = its environment (caller and bus target).
interface axil_reg_master_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_status;

    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;
    logic [1:0]            m_axi_bresp;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic [1:0]            m_axi_rresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
               m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rresp,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_status,
               m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wvalid,
               m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
               m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rresp,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_status,
               m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wvalid,
               m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready
    );

endinterface

// File: rtl/axil_reg_master.sv
// Single-outstanding AXI4-Lite initiator: one register command in, one
// single-beat bus transaction out, exactly one response back (incl. timeout).
module axil_reg_master
    import axil_reg_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              axi_clk,
    input  logic              axi_reset_n,
    axil_reg_master_if.master bus
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_status_q, rsp_status_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;

    logic expire;
    logic abort;
    logic aw_left;
    logic w_left;

    assign expire = (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_ready_d  = cmd_ready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_status_d = rsp_status_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        araddr_d     = araddr_q;
        abort        = 1'b0;
        aw_left      = 1'b0;
        w_left       = 1'b0;

        // Counter saturates so a late handshake still leaves a timeout armed downstream.
        if ((state_q inside {ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_DATA}) && !expire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    cnt_d       = '0;
                    if (bus.cmd_write) begin
                        awaddr_d  = bus.cmd_addr;
                        wdata_d   = bus.cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        araddr_d  = bus.cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end

            ST_WR_REQ: begin
                aw_left = awvalid_q && !bus.m_axi_awready;
                w_left  = wvalid_q && !bus.m_axi_wready;
                if (!aw_left && !w_left) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = ST_WR_RESP;
                end else if (expire) begin
                    abort = 1'b1;
                end else begin
                    awvalid_d = aw_left;
                    wvalid_d  = w_left;
                end
            end

            ST_WR_RESP: begin
                if (bus.m_axi_bvalid) begin
                    bready_d     = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = '0;
                    rsp_status_d = resp_status(bus.m_axi_bresp);
                    state_d      = ST_RSP;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end

            ST_RD_REQ: begin
                if (bus.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end

            ST_RD_DATA: begin
                if (bus.m_axi_rvalid) begin
                    rready_d     = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = bus.m_axi_rdata;
                    rsp_status_d = resp_status(bus.m_axi_rresp);
                    state_d      = ST_RSP;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end

            ST_RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            awvalid_d    = 1'b0;
            wvalid_d     = 1'b0;
            bready_d     = 1'b0;
            arvalid_d    = 1'b0;
            rready_d     = 1'b0;
            rsp_valid_d  = 1'b1;
            rsp_rdata_d  = '0;
            rsp_status_d = RSP_TIMEOUT;
            state_d      = ST_RSP;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cmd_ready_q  <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_status_q <= RSP_OKAY;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            araddr_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            araddr_q     <= araddr_d;
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_status    = rsp_status_q;
    assign bus.m_axi_awaddr  = awaddr_q;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_reg_master.sv
// Bench for axil_reg_master: behavioural AXI4-Lite slave with programmable
// stalls/responses, vector table, scoreboard of expected responses.
`timescale 1ns/1ps
module tb_axil_reg_master;
    import axil_reg_master_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned TO    = 16;
    localparam int          NEVER = 100000;
    localparam int          NV    = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axil_reg_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axil_reg_master #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .axi_clk    (clk),
        .axi_reset_n(rst_n),
        .bus        (bus)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic [1:0]    status;
    } rsp_t;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            aw_d;
        int            w_d;
        int            ar_d;
        logic [1:0]    bresp;
        logic [1:0]    rresp;
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_status;
        int            exp_lat;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    rsp_t sb_q[$];

    // slave configuration and state
    int            aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]    slv_bresp = 2'b00, slv_rresp = 2'b00;
    bit            b_block = 1'b0, slv_flush = 1'b0;
    logic [DW-1:0] regs [16];
    bit            aw_got, w_got;
    logic [AW-1:0] aw_a;
    logic [DW-1:0] w_d;
    int            aw_cnt, w_cnt, ar_cnt;

    // monitor state
    bit rsp_prev = 1'b0;
    int rsp_rise = 0, rsp_rise_cnt = 0, acc_edge = 0;
    int aw_hi = 0, w_hi = 0, ar_hi = 0, b_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input logic [DW-1:0] rdata, input logic [1:0] status);
        rsp_t e;
        e.rdata  = rdata;
        e.status = status;
        sb_q.push_back(e);
    endtask

    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                done     = 1'b1;
                acc_edge = cyc + 1;
            end
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("cmd_accept", 32'(done), 32'd1);
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_wait: outstanding=%0d required=0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // behavioural AXI4-Lite slave: sample at negedge, update just after posedge
    initial begin
        bit            aw_hs, w_hs, bhs, ar_hs, r_hs, awv, wv, arv;
        logic [AW-1:0] awa, ara;
        logic [DW-1:0] wd;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_bresp   = 2'b00;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = 2'b00;
        aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        forever begin
            @(negedge clk);
            awv   = bus.m_axi_awvalid;
            aw_hs = awv && bus.m_axi_awready;
            awa   = bus.m_axi_awaddr;
            wv    = bus.m_axi_wvalid;
            w_hs  = wv && bus.m_axi_wready;
            wd    = bus.m_axi_wdata;
            bhs   = bus.m_axi_bvalid && bus.m_axi_bready;
            arv   = bus.m_axi_arvalid;
            ar_hs = arv && bus.m_axi_arready;
            ara   = bus.m_axi_araddr;
            r_hs  = bus.m_axi_rvalid && bus.m_axi_rready;
            @(posedge clk); #1;
            if (!rst_n || slv_flush) begin
                aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                slv_flush = 1'b0;
                bus.m_axi_awready = 1'b0;
                bus.m_axi_wready  = 1'b0;
                bus.m_axi_arready = 1'b0;
                bus.m_axi_bvalid  = 1'b0;
                bus.m_axi_rvalid  = 1'b0;
            end else begin
                if (aw_hs) begin aw_got = 1'b1; aw_a = awa; aw_cnt = 0; end
                else if (awv) aw_cnt++;
                else aw_cnt = 0;
                if (w_hs) begin w_got = 1'b1; w_d = wd; w_cnt = 0; end
                else if (wv) w_cnt++;
                else w_cnt = 0;
                if (bhs) bus.m_axi_bvalid = 1'b0;
                if (aw_got && w_got && !b_block && !bus.m_axi_bvalid) begin
                    regs[aw_a[5:2]] = w_d;
                    bus.m_axi_bvalid = 1'b1;
                    bus.m_axi_bresp  = slv_bresp;
                    aw_got = 1'b0;
                    w_got  = 1'b0;
                end
                if (r_hs) bus.m_axi_rvalid = 1'b0;
                if (ar_hs) begin
                    bus.m_axi_rvalid = 1'b1;
                    bus.m_axi_rdata  = regs[ara[5:2]];
                    bus.m_axi_rresp  = slv_rresp;
                    ar_cnt = 0;
                end else if (arv) ar_cnt++;
                else ar_cnt = 0;
                bus.m_axi_awready = bus.m_axi_awvalid && (aw_cnt >= aw_delay);
                bus.m_axi_wready  = bus.m_axi_wvalid  && (w_cnt  >= w_delay);
                bus.m_axi_arready = bus.m_axi_arvalid && (ar_cnt >= ar_delay);
            end
        end
    end

    // response monitor / scoreboard consumer
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rsp_prev = 1'b0;
            end else begin
                if (bus.rsp_valid && !rsp_prev) begin
                    rsp_rise = cyc;
                    rsp_rise_cnt++;
                end
                rsp_prev = bus.rsp_valid;
                if (bus.m_axi_awvalid) aw_hi++;
                if (bus.m_axi_wvalid) w_hi++;
                if (bus.m_axi_arvalid) ar_hi++;
                if (bus.m_axi_bvalid && bus.m_axi_bready) b_hs++;
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_unexpected: actual status=%b rdata=0x%08h required=no response",
                                 bus.rsp_status, bus.rsp_rdata);
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_rdata", bus.rsp_rdata, e.rdata);
                        check("rsp_status", 32'(bus.rsp_status), 32'(e.status));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs [NV];
        int   n;
        int   cnt0;

        //        wr  addr    wdata          aw     w  ar     bresp  rresp  exp_rdata      exp_status   lat
        vecs[0]  = '{1'b1, 10'h000, 32'h0000_0001, 0,     0, 0,     2'b00, 2'b00, 32'h0000_0000, RSP_OKAY,    2};
        vecs[1]  = '{1'b0, 10'h000, 32'h0000_0000, 0,     0, 0,     2'b00, 2'b00, 32'h0000_0001, RSP_OKAY,    2};
        vecs[2]  = '{1'b1, 10'h004, 32'hDEAD_BEEF, 0,     0, 0,     2'b00, 2'b00, 32'h0000_0000, RSP_OKAY,    2};
        vecs[3]  = '{1'b0, 10'h004, 32'h0000_0000, 0,     0, 0,     2'b00, 2'b01, 32'hDEAD_BEEF, RSP_OKAY,    2};
        vecs[4]  = '{1'b1, 10'h008, 32'h0000_5A5A, 0,     0, 0,     2'b10, 2'b00, 32'h0000_0000, RSP_SLVERR,  2};
        vecs[5]  = '{1'b0, 10'h008, 32'h0000_0000, 0,     0, 0,     2'b00, 2'b11, 32'h0000_5A5A, RSP_SLVERR,  2};
        vecs[6]  = '{1'b1, 10'h00C, 32'h1234_5678, 3,     0, 0,     2'b00, 2'b00, 32'h0000_0000, RSP_OKAY,    5};
        vecs[7]  = '{1'b1, 10'h00C, 32'hCAFE_F00D, 1,     2, 0,     2'b00, 2'b00, 32'h0000_0000, RSP_OKAY,    4};
        vecs[8]  = '{1'b0, 10'h00C, 32'h0000_0000, 0,     0, 4,     2'b00, 2'b00, 32'hCAFE_F00D, RSP_OKAY,    6};
        vecs[9]  = '{1'b0, 10'h000, 32'h0000_0000, 0,     0, NEVER, 2'b00, 2'b00, 32'h0000_0000, RSP_TIMEOUT, 16};
        vecs[10] = '{1'b1, 10'h004, 32'h0000_0BAD, NEVER, 0, 0,     2'b00, 2'b00, 32'h0000_0000, RSP_TIMEOUT, 16};

        foreach (regs[i]) regs[i] = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_valids", 32'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                                 bus.m_axi_arvalid, bus.m_axi_rready, bus.rsp_valid}), 32'd0);
        check("rst_awaddr", 32'(bus.m_axi_awaddr), 32'd0);
        check("rst_araddr", 32'(bus.m_axi_araddr), 32'd0);
        check("rst_wdata", bus.m_axi_wdata, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_status", 32'(bus.rsp_status), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            aw_delay  = vecs[i].aw_d;
            w_delay   = vecs[i].w_d;
            ar_delay  = vecs[i].ar_d;
            slv_bresp = vecs[i].bresp;
            slv_rresp = vecs[i].rresp;
            aw_hi = 0; w_hi = 0; ar_hi = 0; b_hs = 0;
            expect_rsp(vecs[i].exp_rdata, vecs[i].exp_status);
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            wait_rsp();
            check($sformatf("vec%0d_latency", i), 32'(rsp_rise - acc_edge), 32'(vecs[i].exp_lat));
            if (i == 0) check("slave_reg0", regs[0], 32'h0000_0001);
            if (i == 6) begin
                check("aw_delay_awvalid_cycles", 32'(aw_hi), 32'd4);
                check("aw_delay_wvalid_cycles", 32'(w_hi), 32'd1);
                check("aw_delay_b_handshakes", 32'(b_hs), 32'd1);
            end
            if (i == 9) check("timeout_arvalid_cycles", 32'(ar_hi), 32'(TO));
        end

        aw_delay = 0; w_delay = 0; ar_delay = 0; slv_bresp = 2'b00;
        slv_flush = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // response stall: outputs held, no new command accepted
        slv_rresp     = 2'b10;
        bus.rsp_ready = 1'b0;
        expect_rsp(32'hCAFE_F00D, RSP_SLVERR);
        issue(1'b0, 10'h00C, '0);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("stall%0d_rsp_rdata", k), bus.rsp_rdata, 32'hCAFE_F00D);
            check($sformatf("stall%0d_rsp_status", k), 32'(bus.rsp_status), 32'(RSP_SLVERR));
            check($sformatf("stall%0d_cmd_ready", k), 32'(bus.cmd_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_rsp();
        check("stall_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        slv_rresp = 2'b00;

        // reset while waiting for the write response
        b_block = 1'b1;
        cnt0 = rsp_rise_cnt;
        issue(1'b1, 10'h010, 32'h0000_0077);
        n = 0;
        while (!bus.m_axi_bready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reset_reached_wr_resp", 32'(bus.m_axi_bready), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("reset_async_outputs", 32'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                                          bus.m_axi_arvalid, bus.m_axi_rready, bus.rsp_valid,
                                          bus.cmd_ready}), 32'd0);
        @(posedge clk); #2;
        @(negedge clk);
        rst_n   = 1'b1;
        b_block = 1'b0;
        repeat (10) @(negedge clk);
        check("reset_rsp_lost", 32'(rsp_rise_cnt - cnt0), 32'd0);

        expect_rsp(32'h0, RSP_OKAY);
        issue(1'b1, 10'h010, 32'h0000_0099);
        wait_rsp();
        check("post_reset_write_latency", 32'(rsp_rise - acc_edge), 32'd2);
        expect_rsp(32'h0000_0099, RSP_OKAY);
        issue(1'b0, 10'h010, '0);
        wait_rsp();
        check("post_reset_read_latency", 32'(rsp_rise - acc_edge), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
